menu_key_icon_driver: RTL
=========================

Name: menu_key_icon_driver

Overview:
- Drives a 32x32 menu-icon bitmap renderer. Every pixel clock it produces the renderer's offsetX, offsetY and InsideRectangle inputs from the VGA scan position, so it sits on the upstream side of that interface.
- Adds a press-animation state machine: on a key press the icon is drawn PRESS_SHIFT pixels lower for PRESS_FRAMES frames. A cooldown window follows in which presses are ignored.
- Position changes take effect only at frame boundaries, so the icon never tears mid-frame.

Parameters:
- TOP_LEFT_X, 11'd288, icon left edge in screen pixels.
- TOP_LEFT_Y, 11'd224, icon top edge in its rest position.
- ICON_W, 32, icon width in pixels.
- ICON_H, 32, icon height in pixels.
- PRESS_SHIFT, 2, downward displacement in pixels while pressed.
- PRESS_FRAMES, 8, number of frames the icon stays pressed.
- COOLDOWN_FRAMES, 4, number of frames after release during which presses are ignored.

Ports:
- clk  in  1  pixel clock
- resetN  in  1  reset
- pixelX  in  11  current scan X
- pixelY  in  11  current scan Y
- startOfFrame  in  1  one-cycle pulse at the start of each frame
- enable  in  1  icon visible when 1
- keyPress  in  1  one-cycle press request
- offsetX  out  11  pixelX minus the icon left edge (registered)
- offsetY  out  11  pixelY minus the current icon top edge (registered)
- InsideRectangle  out  1  scan position is inside the icon (registered)
- keyAck  out  1  one-cycle pulse when a press is accepted
- iconPressed  out  1  high while the shifted position is being displayed

Behaviour:
- Reset and clock: reset resetN, asynchronous, active-low; clock clk.
- Reset values: all outputs 0. FSM state = IDLE, frame counter = 0, pending = 0, current top Y = TOP_LEFT_Y.
- Geometry:
  - curTopY is a register; it changes only on a cycle where startOfFrame=1.
  - Inside = enable and pixelX >= TOP_LEFT_X and pixelX < TOP_LEFT_X+ICON_W and pixelY >= curTopY and pixelY < curTopY+ICON_H.
  - All comparisons are unsigned 11-bit and are made before subtraction, so no wrap-around can occur.
  - When Inside=0, offsetX and offsetY are forced to 0.
- Latency: exactly 1 clk. Outputs at cycle n+1 reflect pixelX/pixelY at cycle n, which keeps the downstream renderer at 2 clk total.
- FSM states:
  - IDLE:
    - keyPress=1 sets pending=1 and pulses keyAck on the following cycle.
    - At the next startOfFrame with pending=1: go to PRESSED, curTopY = TOP_LEFT_Y+PRESS_SHIFT, frame counter = 0, pending cleared.
  - PRESSED:
    - The frame counter increments on each startOfFrame.
    - When the counter reaches PRESS_FRAMES-1 and a startOfFrame arrives: go to COOLDOWN, curTopY = TOP_LEFT_Y, counter = 0.
    - keyPress is ignored and no keyAck is given.
  - COOLDOWN:
    - Counts COOLDOWN_FRAMES startOfFrame pulses, then returns to IDLE.
    - keyPress is ignored.
- iconPressed = (state == PRESSED), registered.
- Simultaneous events:
  - keyPress and startOfFrame in the same IDLE cycle: the press is accepted, and the transition to PRESSED happens on that same startOfFrame.
  - A second keyPress while pending=1: ignored, no second keyAck.
- enable=0:
  - Forces InsideRectangle=0.
  - The FSM keeps running, but keyPress is ignored while enable=0.
- Any resetN assertion, including mid-PRESSED: immediate return to IDLE at the rest position on the next frame.

Decomposition:
- Shared package menu_pkg:
  - typedef for the FSM state enum (IDLE, PRESSED, COOLDOWN);
  - localparam for the 11-bit coordinate width;
  - the icon size constant 32.
- One sub-module is natural: frame_counter (counts startOfFrame pulses, with a synchronous clear and a terminal-count flag). It is shared by the PRESSED and COOLDOWN states.

Test Plan:
- Reset, then scan pixel (288,224) with enable=1 -> next cycle InsideRectangle=1, offsetX=0, offsetY=0. Pixel (319,255) -> offsets 31,31. Pixels (320,224) and (287,224) -> InsideRectangle=0 and offsets 0.
- keyPress mid-frame -> keyAck pulses 1 cycle later. Pixel (288,224) stays inside until startOfFrame. After startOfFrame, (288,225) is outside, (288,226) gives offsetY=0, and iconPressed=1.
- After 8 startOfFrame pulses in PRESSED -> rest position is restored and iconPressed=0. A keyPress during the following 4 frames gives no keyAck and no shift. A keyPress after the 4th frame is accepted.
- keyPress and startOfFrame in the same cycle from IDLE -> shift is visible immediately in that frame. Two presses before a frame -> exactly one keyAck.
- enable=0 with the icon fully scanned -> InsideRectangle stays 0. A keyPress during enable=0 gives no keyAck.
- Assert resetN low during PRESSED frame 3 -> all outputs 0 immediately. After release, pixel (288,224) is inside with offsetY=0.

Source files
------------

// File: rtl/menu_key_icon_driver_pkg.sv
// Shared types and constants for the menu key icon driver.
package menu_pkg;

    // Press-animation controller states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESSED  = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    // Width of VGA scan coordinates
    localparam int COORD_W = 11;

    // Icon bitmap edge length in pixels
    localparam int ICON_SIZE = 32;

endpackage

// File: rtl/menu_key_icon_driver_if.sv
// Scan-position / renderer-control bundle between the VGA timing side and the icon driver.
interface menu_key_icon_driver_if;
    import menu_pkg::*;

    logic [COORD_W-1:0] pixelX;
    logic [COORD_W-1:0] pixelY;
    logic               startOfFrame;
    logic               enable;
    logic               keyPress;
    logic [COORD_W-1:0] offsetX;
    logic [COORD_W-1:0] offsetY;
    logic               InsideRectangle;
    logic               keyAck;
    logic               iconPressed;

    // Scan/timing source side
    modport master (
        output pixelX, pixelY, startOfFrame, enable, keyPress,
        input  offsetX, offsetY, InsideRectangle, keyAck, iconPressed
    );

    // Icon driver side
    modport slave (
        input  pixelX, pixelY, startOfFrame, enable, keyPress,
        output offsetX, offsetY, InsideRectangle, keyAck, iconPressed
    );

endinterface

// File: rtl/menu_key_icon_driver_frame_counter.sv
// Counts startOfFrame pulses; synchronous clear wins over counting.
module frame_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             i_sof,
    input  logic             i_clear,
    input  logic [CNT_W-1:0] i_term,
    output logic             o_tc
);
    logic [CNT_W-1:0] r_count;

    // Frame count register: clear has priority, otherwise advance once per frame
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_sof) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tc = (r_count == i_term);

endmodule

// File: rtl/menu_key_icon_driver.sv
// Generates renderer offsets/inside flag from the scan position and animates a key press
// by dropping the icon a few pixels for a number of frames, followed by a cooldown.
module menu_key_icon_driver
    import menu_pkg::*;
#(
    parameter logic [COORD_W-1:0] TOP_LEFT_X      = 11'd288,
    parameter logic [COORD_W-1:0] TOP_LEFT_Y      = 11'd224,
    parameter int                 ICON_W          = ICON_SIZE,
    parameter int                 ICON_H          = ICON_SIZE,
    parameter int                 PRESS_SHIFT     = 2,
    parameter int                 PRESS_FRAMES    = 8,
    parameter int                 COOLDOWN_FRAMES = 4
) (
    input  logic                  clk,
    input  logic                  resetN,
    menu_key_icon_driver_if.slave bus
);
    localparam int                 CNT_W      = 8;
    localparam int                 CW1        = COORD_W + 1;
    localparam logic [CNT_W-1:0]   PRESS_TERM = CNT_W'(PRESS_FRAMES - 1);
    localparam logic [CNT_W-1:0]   COOL_TERM  = CNT_W'(COOLDOWN_FRAMES - 1);
    localparam logic [CW1-1:0]     X_END      = {1'b0, TOP_LEFT_X} + CW1'(ICON_W);
    localparam logic [COORD_W-1:0] SHIFTED_Y  = TOP_LEFT_Y + COORD_W'(PRESS_SHIFT);

    state_t             r_state, w_next_state;
    logic               r_pending, w_next_pending;
    logic [COORD_W-1:0] r_curTopY, w_next_topY;
    logic               r_keyAck, w_ack;
    logic               r_iconPressed;
    logic               w_cnt_clear, w_cnt_tc, w_press_ok;
    logic [CNT_W-1:0]   w_term;

    logic [CW1-1:0]     w_y_end;
    logic               w_inside;
    logic               r_inside;
    logic [COORD_W-1:0] r_offsetX, r_offsetY;

    assign w_term = (r_state == PRESSED) ? PRESS_TERM : COOL_TERM;

    frame_counter #(.CNT_W(CNT_W)) u_frame_counter (
        .clk     (clk),
        .resetN  (resetN),
        .i_sof   (bus.startOfFrame),
        .i_clear (w_cnt_clear),
        .i_term  (w_term),
        .o_tc    (w_cnt_tc)
    );

    // Next-state logic: press capture, frame-aligned position changes, counter control
    always_comb begin
        w_next_state   = r_state;
        w_next_pending = r_pending;
        w_next_topY    = r_curTopY;
        w_ack          = 1'b0;
        w_cnt_clear    = 1'b0;
        w_press_ok     = bus.keyPress && bus.enable && !r_pending;
        unique case (r_state)
            IDLE: begin
                w_cnt_clear = 1'b1;
                if (w_press_ok) begin
                    w_ack          = 1'b1;
                    w_next_pending = 1'b1;
                end
                if (bus.startOfFrame && (r_pending || w_press_ok)) begin
                    w_next_state   = PRESSED;
                    w_next_topY    = SHIFTED_Y;
                    w_next_pending = 1'b0;
                end
            end
            PRESSED: begin
                if (bus.startOfFrame && w_cnt_tc) begin
                    w_next_state = COOLDOWN;
                    w_next_topY  = TOP_LEFT_Y;
                    w_cnt_clear  = 1'b1;
                end
            end
            COOLDOWN: begin
                if (bus.startOfFrame && w_cnt_tc) begin
                    w_next_state = IDLE;
                    w_cnt_clear  = 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_topY  = TOP_LEFT_Y;
            end
        endcase
    end

    // Controller registers and registered status outputs
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state       <= IDLE;
            r_pending     <= 1'b0;
            r_curTopY     <= TOP_LEFT_Y;
            r_keyAck      <= 1'b0;
            r_iconPressed <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_pending     <= w_next_pending;
            r_curTopY     <= w_next_topY;
            r_keyAck      <= w_ack;
            r_iconPressed <= (w_next_state == PRESSED);
        end
    end

    // Range tests on unsigned coordinates before any subtraction, so offsets never wrap
    assign w_y_end  = {1'b0, r_curTopY} + CW1'(ICON_H);
    assign w_inside = bus.enable
                   && (bus.pixelX >= TOP_LEFT_X) && ({1'b0, bus.pixelX} < X_END)
                   && (bus.pixelY >= r_curTopY)  && ({1'b0, bus.pixelY} < w_y_end);

    // One-cycle geometry stage feeding the renderer
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_inside  <= 1'b0;
            r_offsetX <= '0;
            r_offsetY <= '0;
        end else begin
            r_inside  <= w_inside;
            r_offsetX <= w_inside ? (bus.pixelX - TOP_LEFT_X) : '0;
            r_offsetY <= w_inside ? (bus.pixelY - r_curTopY)  : '0;
        end
    end

    assign bus.InsideRectangle = r_inside;
    assign bus.offsetX         = r_offsetX;
    assign bus.offsetY         = r_offsetY;
    assign bus.keyAck          = r_keyAck;
    assign bus.iconPressed     = r_iconPressed;

endmodule
